// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit for register-to-register ALU instructions; optional memory-wait in T1 via `ifdef CS_MEM_WAIT_EN
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic [31:0]     IR,
  input  logic            Stop,
`ifdef CS_MEM_WAIT_EN
  input  logic            Mem_ready,
`endif
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            MARin,
  output logic            Zin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [ALUW-1:0] ALU_op,
  output logic            Run,
  output logic            Illegal
);
  typedef enum logic [2:0] {RST, T0, T1, T2, T3, T4, T5, HALT} state_t;
  state_t state_q, state_d, done_st;
  logic stop_q, stop_d, mem_ok, is_bin, is_un, is_nop, is_halt;
  logic [OPW-1:0] op;
  logic [ALUW-1:0] alu_code;
  assign op       = IR[31 -: OPW];
  assign is_bin   = op >= OPW'(3) && op <= OPW'(8);
  assign is_un    = op == OPW'(15) || op == OPW'(16);
  assign is_nop   = op == OPW'(26);
  assign is_halt  = op == OPW'(27);
  assign alu_code = is_bin ? ALUW'(op - OPW'(2)) : op == OPW'(15) ? ALUW'(7) : op == OPW'(16) ? ALUW'(8) : '0;
`ifdef CS_MEM_WAIT_EN
  assign mem_ok = Mem_ready;
`else
  assign mem_ok = 1'b1;
`endif
  // next state: an instruction boundary diverts to HALT once a stop request has been seen
  always_comb begin
    done_st = (stop_q || Stop) ? HALT : T0;
    stop_d  = Clear ? 1'b0 : (stop_q || Stop);
    state_d = state_q;
    case (state_q)
      RST:     state_d = T0;
      T0:      state_d = T1;
      T1:      state_d = mem_ok ? T2 : T1;
      T2:      state_d = T3;
      T3:      state_d = (is_bin || is_un) ? T4 : is_halt ? HALT : done_st;
      T4:      state_d = is_bin ? T5 : done_st;
      T5:      state_d = done_st;
      default: state_d = HALT;
    endcase
    if (Clear) state_d = RST;
  end
  // state and sticky stop flag
  always_ff @(posedge Clock) begin
    state_q <= state_d;
    stop_q  <= stop_d;
  end
  // Moore strobe decode from state and the instruction held in IR
  always_comb begin
    {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read} = '0;
    {Gra, Grb, Grc, Rin, Rout, Illegal} = '0;
    ALU_op = '0;
    Run    = state_q inside {T0, T1, T2, T3, T4, T5};
    case (state_q)
      T0: {PCout, MARin, IncPC, Zin} = '1;
      T1: {Zlowout, PCin, Read, MDRin} = '1;
      T2: {MDRout, IRin} = '1;
      T3: begin
        {Grb, Rout} = {2{is_bin || is_un}};
        Yin     = is_bin;
        Zin     = is_un;
        ALU_op  = is_un ? alu_code : '0;
        Illegal = !(is_bin || is_un || is_nop || is_halt);
      end
      T4: begin
        {Grc, Rout, Zin} = {3{is_bin}};
        ALU_op = is_bin ? alu_code : '0;
        {Zlowout, Gra, Rin} = {3{is_un}};
      end
      T5: {Zlowout, Gra, Rin} = '1;
      default: ;
    endcase
  end
endmodule
